// File: rtl/speech256_seq_pkg.sv
// Shared definitions for the allophone sequencer.
//   seq_state_e : sequencer FSM state encoding
//   CODE_W      : allophone code width
//   ALLO_PA1    : default terminating pause allophone (PA1)
package speech256_seq_pkg;

    localparam int unsigned CODE_W = 6;

    localparam logic [CODE_W-1:0] ALLO_PA1 = 6'd0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_PAUSE     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/allophone_fifo.sv
// Synchronous FIFO holding allophone codes between host and sequencer.
// Ports:
//   clk, rst_an : clock, asynchronous active-low reset
//   clr         : synchronous clear of pointers and occupancy
//   wr, din     : enqueue request and data (ignored while full)
//   rd          : pop request (ignored while empty)
//   dout        : current head entry, read combinationally from storage
//   count       : occupancy 0..DEPTH (registered)
//   full, empty : registered occupancy flags
module allophone_fifo
    import speech256_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst_an,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    input  logic [CODE_W-1:0] din,
    output logic [CODE_W-1:0] dout,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              full_q, empty_q;
    logic              wr_en_s, rd_en_s;

    // Qualified pointer/occupancy update; pointers wrap naturally at AW bits.
    always_comb begin
        wr_en_s  = wr && !full_q && !clr;
        rd_en_s  = rd && !empty_q && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == {(AW+1){1'b0}});
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/allophone_sequencer.sv
// Buffers a host-written phrase of allophones and feeds them one at a time
// into the speech core load handshake (ldq / data_in / data_stb), optionally
// appending a pause allophone when the phrase drains.
// Ports:
//   clk, rst_an          : clock, asynchronous active-low reset
//   host_data, host_wr   : host enqueue data and one-cycle write strobe
//   flush                : synchronous clear of FIFO, overflow and sequencer
//   host_full, host_count: FIFO status to the host
//   overflow             : sticky, a write arrived while full
//   busy, done           : phrase in progress / one-cycle completion pulse
//   ldq                  : core ready for a new allophone
//   data_out, data_stb   : allophone and one-cycle load strobe to the core
module allophone_sequencer
    import speech256_seq_pkg::*;
#(
    parameter int                DEPTH      = 16,
    parameter int                AW         = 4,
    parameter int                AUTO_PAUSE = 1,
    parameter logic [CODE_W-1:0] PAUSE_CODE = ALLO_PA1
) (
    input  logic              clk,
    input  logic              rst_an,
    input  logic [CODE_W-1:0] host_data,
    input  logic              host_wr,
    input  logic              flush,
    output logic              host_full,
    output logic [AW:0]       host_count,
    output logic              overflow,
    output logic              busy,
    output logic              done,
    input  logic              ldq,
    output logic [CODE_W-1:0] data_out,
    output logic              data_stb
);

    seq_state_e        state_q, state_d;
    logic [CODE_W-1:0] data_out_q, data_out_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;
    logic              data_stb_q, data_stb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;

    logic              fifo_wr_s, fifo_rd_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [CODE_W-1:0] fifo_dout_s;
    logic [AW:0]       fifo_count_s;

    assign fifo_wr_s = host_wr && !flush;

    allophone_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .rst_an (rst_an),
        .clr    (flush),
        .wr     (fifo_wr_s),
        .rd     (fifo_rd_s),
        .din    (host_data),
        .dout   (fifo_dout_s),
        .count  (fifo_count_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. WAIT_LOW guards against reloading while ldq is still
    // stale-high from before the core reacted to the previous strobe.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s && ldq) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: state_d = ST_WAIT_LOW;
                ST_WAIT_LOW: begin
                    if (!ldq) begin
                        state_d = ST_WAIT_HIGH;
                    end else begin
                        state_d = ST_WAIT_LOW;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!ldq) begin
                        state_d = ST_WAIT_HIGH;
                    end else if (!fifo_empty_s) begin
                        state_d = ST_ISSUE;
                    end else if ((AUTO_PAUSE != 0) && (last_code_q != PAUSE_CODE)) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PAUSE: state_d = ST_WAIT_LOW;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output next-values. The strobe and its data are registered on entry to
    // ISSUE/PAUSE so data_stb is high exactly while the FSM sits in that state.
    always_comb begin
        fifo_rd_s   = 1'b0;
        data_stb_d  = 1'b0;
        data_out_d  = data_out_q;
        last_code_d = last_code_q;
        if (state_d == ST_ISSUE) begin
            fifo_rd_s   = 1'b1;
            data_stb_d  = 1'b1;
            data_out_d  = fifo_dout_s;
            last_code_d = fifo_dout_s;
        end else if (state_d == ST_PAUSE) begin
            fifo_rd_s   = 1'b0;
            data_stb_d  = 1'b1;
            data_out_d  = PAUSE_CODE;
            last_code_d = PAUSE_CODE;
        end else begin
            fifo_rd_s   = 1'b0;
            data_stb_d  = 1'b0;
            data_out_d  = data_out_q;
            last_code_d = last_code_q;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = !flush && (state_q == ST_WAIT_HIGH) && (state_d == ST_IDLE);
        if (flush) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q || (host_wr && fifo_full_s);
        end
    end

    // Registered outputs and sequencer bookkeeping.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            data_out_q  <= {CODE_W{1'b0}};
            last_code_q <= {CODE_W{1'b0}};
            data_stb_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            last_code_q <= last_code_d;
            data_stb_q  <= data_stb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_stb   = data_stb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign host_count = fifo_count_s;
    assign host_full  = fifo_full_s;

endmodule

// File: doc/allophone_sequencer.md
# allophone_sequencer

Buffers a phrase of 6-bit allophone codes written by a host and feeds them, one at a time, into the speech core's `ldq`/`data_in`/`data_stb` load handshake. It sits between the host interface and the speech core top level, so the host can write a whole phrase in a burst instead of polling `ldq` per allophone. Optionally, it appends a pause allophone when the buffer drains, so the core ends on silence. It reports phrase completion back to the host.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, minimum 2.
- `AW`, 4: log2(`DEPTH`).
- `AUTO_PAUSE`, 1: 1 appends `PAUSE_CODE` when the FIFO drains after at least one issued allophone.
- `PAUSE_CODE`, 6'd0: allophone code used as the terminating pause (PA1).

- `clk` in 1: global Speech256 clock (256*10 kHz).
- `rst_an` in 1: asynchronous, active-low reset.
- `host_data` in 6: allophone code to enqueue.
- `host_wr` in 1: one-cycle write strobe; enqueues `host_data`.
- `flush` in 1: synchronous clear of FIFO, overflow flag and sequencer state.
- `host_full` out 1: FIFO holds `DEPTH` entries.
- `host_count` out AW+1: current FIFO occupancy, 0..`DEPTH`.
- `overflow` out 1: sticky; set by a write while full.
- `busy` out 1: high from the first dequeue until `done`.
- `done` out 1: one-cycle pulse when a phrase completes.
- `ldq` in 1: from the speech core; high when the core can accept an allophone.
- `data_out` out 6: allophone to the core `data_in`; registered; holds its value between strobes.
- `data_stb` out 1: one-cycle load strobe to the core `data_stb`.

## Operation
- **FIFO:**
  - Write when `host_wr` && !full.
  - A write while full is dropped and sets `overflow`.
  - Read is internal, performed in state ISSUE.
  - Simultaneous read and write leaves `host_count` unchanged.
  - Pointers are AW bits and wrap modulo `DEPTH`.
- **FSM states:**
  - IDLE
  - ISSUE: `data_stb`=1 for exactly one cycle.
  - WAIT_LOW: wait for the core to drop `ldq`.
  - WAIT_HIGH: wait for `ldq`=1 again.
  - PAUSE: issue `PAUSE_CODE`.
- **Transitions:**
  - IDLE: !empty && `ldq` → ISSUE. The FIFO head is latched into `data_out` and popped; `busy` is set.
  - ISSUE → WAIT_LOW unconditionally.
  - WAIT_LOW: `ldq`=0 → WAIT_HIGH. This prevents a double load while `ldq` is still stale-high.
  - WAIT_HIGH, on `ldq`=1:
    - !empty → ISSUE with the next entry.
    - empty && `AUTO_PAUSE` && last issued code != `PAUSE_CODE` → PAUSE.
    - Otherwise → IDLE, pulsing `done` and clearing `busy`.
  - PAUSE: `data_out`=`PAUSE_CODE`, `data_stb`=1 for one cycle, mark the pause as issued → WAIT_LOW.
- **`flush`:**
  - Has priority over `host_wr` and any FSM transition.
  - Next cycle: count=0, `overflow`=0, state=IDLE, `busy`=0, `data_stb`=0.
  - Does not pulse `done`.
  - `data_out` keeps its last value.
- **Reset values:** `data_out`=0, `data_stb`=0, `busy`=0, `done`=0, `overflow`=0, `host_count`=0, `host_full`=0, state=IDLE.
- **Reset mid-phrase:** everything returns to the reset values asynchronously. No strobe is emitted on release.

## Timing
- All outputs are registered.
- `host_wr` at edge N updates `host_count`/`host_full` after edge N.
- Empty FIFO, `ldq`=1, write at edge N: `data_stb` is high in cycle N+2 (write at N, IDLE sees non-empty at N+1, ISSUE at N+2).
- Minimum spacing between strobes is 3 cycles: ISSUE, WAIT_LOW, WAIT_HIGH with `ldq` responding immediately.
- `done` is asserted in the cycle after the final WAIT_HIGH→IDLE decision.
- `ldq` is sampled directly. It is generated in the same clock domain, so no synchronizer is needed.

## Structure
- Package `speech256_seq_pkg`: FSM state encoding (IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, PAUSE) and the default pause code `ALLO_PA1` = 6'd0.
- Sub-module `allophone_fifo`:
  - Synchronous FIFO, parameterised by DEPTH and AW.
  - Ports: wr, rd, din, dout, count, full, empty, clr.
  - `dout` is the FIFO head, combinational from the RAM read.
- FSM, output registers and overflow flag live in the top of the block.

## Test plan
- Write codes 5, 9, 13 with `ldq` held 1 and a core model that drops `ldq` for 4 cycles after each strobe → `data_out`=5,9,13 then 0 (pause), each with a single-cycle `data_stb`; `done` pulses once; `busy` falls with `done`.
- `ldq` held 1 permanently after a strobe (stale core) → exactly one strobe; FSM stays in WAIT_LOW; no second load.
- Write 17 entries with `DEPTH`=16 and `ldq`=0 → `host_full`=1 and `overflow`=1, `host_count`=16; after enabling `ldq`, 16 codes emerge in order.
- Simultaneous `host_wr` and internal pop with count=3 → count stays 3; data order is preserved across pointer wrap after 40 total writes.
- `flush` in WAIT_HIGH with 4 entries queued → count=0, state IDLE, no further `data_stb`, no `done`.
- `AUTO_PAUSE`=0, single code 7 → one strobe with 7 and no pause strobe. Separately, with `AUTO_PAUSE`=1 and last code=`PAUSE_CODE` → no extra pause is appended.
